// File: rtl/cpu_dma_master_sm_if.sv
// FIFO-side and 68030 bus-side signals of the CPU DMA master sequencer.
// The master modport is the sequencer's view; slave is the bus/FIFO side.
interface cpu_dma_master_sm_if #(
  parameter int SW = 4
);
  logic          DMAENA;
  logic          DMADIR;
  logic          FIFOEMPTY;
  logic          FIFOFULL;
  logic          FLUSHFIFO;
  logic          LASTWORD;
  logic          BG_;
  logic          DSACK0_;
  logic          DSACK1_;
  logic          BERR_;
  logic          BR_;
  logic          BGACK_;
  logic          AS_;
  logic          DS_;
  logic          R_W;
  logic [1:0]    SIZ;
  logic          A1;
  logic          FIFO_POP;
  logic          FIFO_PUSH;
  logic          HW_LATCH;
  logic          INC_ADD;
  logic          BUSERR;
  logic [SW-1:0] STATE;

  modport master (
    input  DMAENA, DMADIR, FIFOEMPTY, FIFOFULL, FLUSHFIFO, LASTWORD,
           BG_, DSACK0_, DSACK1_, BERR_,
    output BR_, BGACK_, AS_, DS_, R_W, SIZ, A1,
           FIFO_POP, FIFO_PUSH, HW_LATCH, INC_ADD, BUSERR, STATE
  );

  modport slave (
    output DMAENA, DMADIR, FIFOEMPTY, FIFOFULL, FLUSHFIFO, LASTWORD,
           BG_, DSACK0_, DSACK1_, BERR_,
    input  BR_, BGACK_, AS_, DS_, R_W, SIZ, A1,
           FIFO_POP, FIFO_PUSH, HW_LATCH, INC_ADD, BUSERR, STATE
  );
endinterface

// File: rtl/cpu_dma_master_sm.sv
// CPU-side DMA bus master: arbitrates for the 68030 bus, runs bursts of
// longword cycles with dynamic bus sizing, and aborts on timeout or BERR_.
module cpu_dma_master_sm #(
  parameter int BURST_MAX   = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int SW          = 4
) (
  input  logic                SCLK,
  input  logic                RST,
  cpu_dma_master_sm_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ACK  = 3'd2;
  localparam logic [2:0] S_ADDR = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_TERM = 3'd5;
  localparam logic [2:0] S_NEXT = 3'd6;
  localparam logic [2:0] S_REL  = 3'd7;

  localparam int            TW        = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    BURST_LIM = 8'(BURST_MAX);

  logic [2:0]    state_q, state_d;
  logic [7:0]    burst_q, burst_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          buserr_q, buserr_d;
  logic          dir_q, dir_d;
  logic          lw_q, lw_d;      // current transfer is a single LASTWORD halfword
  logic          a1_q, a1_d;      // second halfword of a 16-bit port longword
  logic          half_q, half_d;  // TERM separating the two halfwords

  logic start_ok;
  logic no_ack;
  logic ack32;
  logic ack16;
  logic fault;
  logic in_cyc;
  logic term_done;

  assign start_ok = bus.DMAENA &
                    (bus.DMADIR ? (bus.FIFOFULL | (bus.FLUSHFIFO & ~bus.FIFOEMPTY))
                                : ~bus.FIFOFULL);

  assign no_ack = bus.DSACK1_ & bus.DSACK0_;
  assign ack32  = ~bus.DSACK1_ & ~bus.DSACK0_;
  assign ack16  = ~bus.DSACK1_ &  bus.DSACK0_;
  // An 8-bit port, BERR_ or an expired wait all abort; BERR_ beats any DSACK.
  assign fault  = ~bus.BERR_ | (bus.DSACK1_ & ~bus.DSACK0_) |
                  (no_ack & (tmo_q == TMO_LAST));

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    state_d  = state_q;
    burst_d  = burst_q;
    tmo_d    = tmo_q;
    buserr_d = buserr_q;
    dir_d    = dir_q;
    lw_d     = lw_q;
    a1_d     = a1_q;
    half_d   = half_q;

    if (!bus.DMAENA) buserr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok && !buserr_q) begin
          state_d = S_REQ;
          dir_d   = bus.DMADIR;
        end
      end
      S_REQ: begin
        if (!bus.DMAENA)  state_d = S_IDLE;
        else if (!bus.BG_) state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_ADDR;
        lw_d    = bus.LASTWORD & bus.FLUSHFIFO;
        a1_d    = 1'b0;
      end
      S_ADDR: begin
        state_d = S_DATA;
        tmo_d   = '0;
      end
      S_DATA: begin
        if (fault) begin
          buserr_d = 1'b1;
          state_d  = S_REL;
        end else if (ack32 || (ack16 && (lw_q || a1_q))) begin
          state_d = S_TERM;
        end else if (ack16) begin
          state_d = S_TERM;
          half_d  = 1'b1;
          a1_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_TERM: begin
        // A halfword TERM only negates the strobes; the longword is not done.
        if (half_q) begin
          half_d  = 1'b0;
          state_d = S_ADDR;
        end else begin
          burst_d = burst_q + 8'd1;
          a1_d    = 1'b0;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (start_ok && (bus.DMADIR == dir_q) && (burst_q < BURST_LIM) && !lw_q) begin
          state_d = S_ADDR;
          lw_d    = bus.LASTWORD & bus.FLUSHFIFO;
        end else begin
          state_d = S_REL;
        end
      end
      default: begin
        burst_d = '0;
        lw_d    = 1'b0;
        a1_d    = 1'b0;
        half_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge SCLK or posedge RST) begin
    // NOTE: non-blocking updates keep every register sampling pre-edge values.
    if (RST) begin
      state_q  <= S_IDLE;
      burst_q  <= '0;
      tmo_q    <= '0;
      buserr_q <= 1'b0;
      dir_q    <= 1'b0;
      lw_q     <= 1'b0;
      a1_q     <= 1'b0;
      half_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      tmo_q    <= tmo_d;
      buserr_q <= buserr_d;
      dir_q    <= dir_d;
      lw_q     <= lw_d;
      a1_q     <= a1_d;
      half_q   <= half_d;
    end
  end

  // Outputs decode straight from state so a reset negates strobes at once.
  assign in_cyc    = (state_q == S_ADDR) || (state_q == S_DATA);
  assign term_done = (state_q == S_TERM) && !half_q;

  assign bus.BR_       = (state_q != S_REQ);
  assign bus.BGACK_    = !((state_q == S_ACK) || in_cyc ||
                           (state_q == S_TERM) || (state_q == S_NEXT));
  assign bus.AS_       = !in_cyc;
  assign bus.DS_       = (state_q != S_DATA);
  assign bus.R_W       = in_cyc ? !dir_q : 1'b1;
  assign bus.SIZ       = (in_cyc && (lw_q || a1_q)) ? 2'b10 : 2'b00;
  assign bus.A1        = in_cyc && a1_q;
  assign bus.FIFO_POP  = term_done && dir_q;
  assign bus.FIFO_PUSH = term_done && !dir_q;
  assign bus.HW_LATCH  = (state_q == S_TERM) && half_q && !dir_q;
  assign bus.INC_ADD   = term_done;
  assign bus.BUSERR    = buserr_q;
  assign bus.STATE     = SW'(state_q);

endmodule

// File: tb/tb_cpu_dma_master_sm.sv
// Directed bench for cpu_dma_master_sm: start-condition table plus bus
// sequences against a small arbiter/slave model with selectable port width.
module tb_cpu_dma_master_sm;

  localparam int SW = 4;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_REQ  = 4'd1;
  localparam logic [3:0] ST_REL  = 4'd7;

  typedef struct {
    bit         ena;
    bit         dir;
    bit         empty;
    bit         full;
    bit         flush;
    logic [3:0] exp_state;
  } start_vec_t;

  logic SCLK = 1'b0;
  logic RST;

  cpu_dma_master_sm_if #(.SW(SW)) bus ();

  cpu_dma_master_sm #(
    .BURST_MAX  (4),
    .TIMEOUT_CYC(64),
    .SW         (SW)
  ) dut (
    .SCLK(SCLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 SCLK = ~SCLK;

  int checks   = 0;
  int failures = 0;

  // 0 = never acknowledges, 1 = 32-bit, 2 = 16-bit, 3 = 8-bit
  int port_mode = 1;
  int ack_delay = 1;
  bit berr_mode = 1'b0;

  int pop_cnt, push_cnt, hw_cnt, inc_cnt, as_cnt, br_cnt, bgack_cnt, both_cnt;
  logic       a1_log[$];
  logic [1:0] siz_log[$];
  logic       rw_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arbiter grants two cycles after BR_; slave acks ack_delay cycles into DS_.
  initial begin : slave_model
    int br_wait;
    int ds_wait;
    bit resp;
    br_wait = 0;
    ds_wait = 0;
    bus.BG_     = 1'b1;
    bus.DSACK0_ = 1'b1;
    bus.DSACK1_ = 1'b1;
    bus.BERR_   = 1'b1;
    forever begin
      @(negedge SCLK);
      br_wait     = (bus.BR_ === 1'b0) ? br_wait + 1 : 0;
      bus.BG_     = !(br_wait >= 2);
      ds_wait     = (bus.DS_ === 1'b0) ? ds_wait + 1 : 0;
      resp        = (ds_wait > 0) && (ds_wait >= ack_delay);
      bus.DSACK1_ = !(resp && (port_mode == 1 || port_mode == 2));
      bus.DSACK0_ = !(resp && (port_mode == 1 || port_mode == 3));
      bus.BERR_   = !(resp && berr_mode);
    end
  end

  initial begin : monitor
    logic as_prev, br_prev, bgack_prev;
    as_prev = 1'b1; br_prev = 1'b1; bgack_prev = 1'b1;
    forever begin
      @(negedge SCLK);
      if (bus.FIFO_POP  === 1'b1) pop_cnt++;
      if (bus.FIFO_PUSH === 1'b1) push_cnt++;
      if (bus.HW_LATCH  === 1'b1) hw_cnt++;
      if (bus.INC_ADD   === 1'b1) inc_cnt++;
      if (bus.FIFO_POP === 1'b1 && bus.FIFO_PUSH === 1'b1) both_cnt++;
      if (as_prev === 1'b1 && bus.AS_ === 1'b0) begin
        as_cnt++;
        a1_log.push_back(bus.A1);
        siz_log.push_back(bus.SIZ);
        rw_log.push_back(bus.R_W);
      end
      if (br_prev === 1'b1 && bus.BR_ === 1'b0) br_cnt++;
      if (bgack_prev === 1'b1 && bus.BGACK_ === 1'b0) bgack_cnt++;
      as_prev    = bus.AS_;
      br_prev    = bus.BR_;
      bgack_prev = bus.BGACK_;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge SCLK);
    #2;
  endtask

  task automatic idle_inputs();
    bus.DMAENA    = 1'b0;
    bus.DMADIR    = 1'b0;
    bus.FIFOEMPTY = 1'b1;
    bus.FIFOFULL  = 1'b0;
    bus.FLUSHFIFO = 1'b0;
    bus.LASTWORD  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    berr_mode = 1'b0;
    RST = 1'b1;
    #1;
    RST = 1'b0;
  endtask

  task automatic start_write_full();
    bus.DMADIR    = 1'b1;
    bus.FIFOEMPTY = 1'b0;
    bus.FIFOFULL  = 1'b1;
    bus.DMAENA    = 1'b1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string name);
    for (int i = 0; i < budget && bus.STATE !== s; i++) tick();
    check(name, bus.STATE, s);
  endtask

  task automatic run_fault(input int port, input bit berr, input string name);
    int b_pop, b_br;
    do_reset();
    port_mode = port;
    ack_delay = 1;
    berr_mode = berr;
    b_pop = pop_cnt;
    b_br  = br_cnt;
    start_write_full();
    wait_state(ST_REL, 50, {name, "_rel"});
    check({name, "_buserr"}, bus.BUSERR, 1);
    tick(); tick(); tick();
    check({name, "_no_pop"}, pop_cnt - b_pop, 0);
    check({name, "_no_rereq"}, br_cnt - b_br, 1);
    check({name, "_idle"}, bus.STATE, ST_IDLE);
    bus.DMAENA = 1'b0;
    berr_mode  = 1'b0;
  endtask

  initial begin : main
    start_vec_t vecs[9];
    int b_pop, b_push, b_hw, b_inc, b_as, b_br, b_bg, ds_low, n;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ST_IDLE};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ST_REQ};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ST_REQ};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, ST_IDLE};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ST_REQ};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ST_IDLE};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ST_REQ};

    RST = 1'b1;
    idle_inputs();
    tick(); tick();
    check("rst_br",     bus.BR_, 1);
    check("rst_bgack",  bus.BGACK_, 1);
    check("rst_as",     bus.AS_, 1);
    check("rst_ds",     bus.DS_, 1);
    check("rst_rw",     bus.R_W, 1);
    check("rst_siz",    bus.SIZ, 0);
    check("rst_a1",     bus.A1, 0);
    check("rst_pulses", {bus.FIFO_POP, bus.FIFO_PUSH, bus.HW_LATCH, bus.INC_ADD}, 0);
    check("rst_buserr", bus.BUSERR, 0);
    check("rst_state",  bus.STATE, ST_IDLE);
    RST = 1'b0;
    tick();
    check("idle_hold", bus.STATE, ST_IDLE);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      bus.DMAENA    = vecs[i].ena;
      bus.DMADIR    = vecs[i].dir;
      bus.FIFOEMPTY = vecs[i].empty;
      bus.FIFOFULL  = vecs[i].full;
      bus.FLUSHFIFO = vecs[i].flush;
      tick();
      check($sformatf("start%0d_state", i), bus.STATE, vecs[i].exp_state);
      check($sformatf("start%0d_br", i), bus.BR_, (vecs[i].exp_state == ST_REQ) ? 0 : 1);
    end

    // Write burst, 32-bit port: four longwords per tenure.
    do_reset();
    port_mode = 1; ack_delay = 2;
    b_pop = pop_cnt; b_push = push_cnt; b_inc = inc_cnt;
    b_as = as_cnt; b_br = br_cnt; b_bg = bgack_cnt;
    start_write_full();
    wait_state(ST_REL, 200, "burst_rel");
    check("burst_rel_bgack", bus.BGACK_, 1);
    bus.DMAENA = 1'b0;
    tick(); tick();
    check("burst_pop",   pop_cnt - b_pop, 4);
    check("burst_inc",   inc_cnt - b_inc, 4);
    check("burst_push",  push_cnt - b_push, 0);
    check("burst_as",    as_cnt - b_as, 4);
    check("burst_br",    br_cnt - b_br, 1);
    check("burst_bgack", bgack_cnt - b_bg, 1);
    check("burst_idle",  bus.STATE, ST_IDLE);
    check("burst_rw",    rw_log[b_as], 0);
    check("burst_siz",   siz_log[b_as], 0);

    // Read burst, 16-bit port: two halfword cycles per longword.
    do_reset();
    port_mode = 2; ack_delay = 1;
    b_pop = pop_cnt; b_push = push_cnt; b_hw = hw_cnt; b_inc = inc_cnt; b_as = as_cnt;
    bus.DMADIR = 1'b0; bus.FIFOEMPTY = 1'b1; bus.FIFOFULL = 1'b0; bus.DMAENA = 1'b1;
    wait_state(ST_REL, 200, "rd16_rel");
    bus.DMAENA = 1'b0;
    tick();
    check("rd16_push", push_cnt - b_push, 4);
    check("rd16_hw",   hw_cnt - b_hw, 4);
    check("rd16_inc",  inc_cnt - b_inc, 4);
    check("rd16_pop",  pop_cnt - b_pop, 0);
    check("rd16_as",   as_cnt - b_as, 8);
    check("rd16_a1_first",  a1_log[b_as], 0);
    check("rd16_a1_second", a1_log[b_as + 1], 1);
    check("rd16_siz_first",  siz_log[b_as], 0);
    check("rd16_siz_second", siz_log[b_as + 1], 2);
    check("rd16_rw", rw_log[b_as], 1);

    // LASTWORD flush: one halfword cycle, then release.
    do_reset();
    port_mode = 2; ack_delay = 1;
    b_pop = pop_cnt; b_inc = inc_cnt; b_hw = hw_cnt; b_as = as_cnt;
    bus.DMADIR = 1'b1; bus.FIFOEMPTY = 1'b0; bus.FIFOFULL = 1'b0;
    bus.FLUSHFIFO = 1'b1; bus.LASTWORD = 1'b1; bus.DMAENA = 1'b1;
    wait_state(ST_REL, 100, "flush_rel");
    bus.DMAENA = 1'b0;
    tick();
    check("flush_as",  as_cnt - b_as, 1);
    check("flush_siz", siz_log[b_as], 2);
    check("flush_a1",  a1_log[b_as], 0);
    check("flush_pop", pop_cnt - b_pop, 1);
    check("flush_inc", inc_cnt - b_inc, 1);
    check("flush_hw",  hw_cnt - b_hw, 0);

    // DSACK timeout: DS_ held for exactly TIMEOUT_CYC cycles.
    do_reset();
    port_mode = 0;
    b_pop = pop_cnt; b_br = br_cnt;
    start_write_full();
    ds_low = 0;
    n = 0;
    while (n < 200 && bus.BUSERR !== 1'b1) begin
      tick();
      n++;
      if (bus.BUSERR !== 1'b1 && bus.DS_ === 1'b0) ds_low++;
    end
    check("tmo_ds_cycles", ds_low, 64);
    check("tmo_buserr", bus.BUSERR, 1);
    check("tmo_state",  bus.STATE, ST_REL);
    check("tmo_as",     bus.AS_, 1);
    check("tmo_ds",     bus.DS_, 1);
    tick(); tick(); tick(); tick();
    check("tmo_no_pop",    pop_cnt - b_pop, 0);
    check("tmo_no_rereq",  br_cnt - b_br, 1);
    check("tmo_hold_idle", bus.STATE, ST_IDLE);
    bus.DMAENA = 1'b0;
    tick();
    check("tmo_clear", bus.BUSERR, 0);
    bus.DMAENA = 1'b1;
    tick();
    check("tmo_rearm", bus.STATE, ST_REQ);

    // DMAENA drops during the first half of a 16-bit write.
    do_reset();
    port_mode = 2; ack_delay = 3;
    b_pop = pop_cnt; b_as = as_cnt; b_inc = inc_cnt;
    start_write_full();
    for (int i = 0; i < 50 && bus.DS_ !== 1'b0; i++) tick();
    check("drop_in_data", bus.DS_, 0);
    check("drop_first_half", bus.A1, 0);
    bus.DMAENA = 1'b0;
    wait_state(ST_REL, 50, "drop_rel");
    check("drop_bgack",  bus.BGACK_, 1);
    check("drop_pop",    pop_cnt - b_pop, 1);
    check("drop_inc",    inc_cnt - b_inc, 1);
    check("drop_as",     as_cnt - b_as, 2);
    check("drop_buserr", bus.BUSERR, 0);

    run_fault(3, 1'b0, "port8");
    run_fault(1, 1'b1, "berr_wins");

    // Reset asserted while AS_ is low.
    do_reset();
    port_mode = 0;
    b_pop = pop_cnt; b_inc = inc_cnt;
    start_write_full();
    for (int i = 0; i < 50 && bus.AS_ !== 1'b0; i++) tick();
    check("midrst_as_low", bus.AS_, 0);
    RST = 1'b1;
    #1;
    check("midrst_as",    bus.AS_, 1);
    check("midrst_ds",    bus.DS_, 1);
    check("midrst_bgack", bus.BGACK_, 1);
    check("midrst_state", bus.STATE, ST_IDLE);
    bus.DMAENA = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    check("midrst_no_pop", pop_cnt - b_pop, 0);
    check("midrst_no_inc", inc_cnt - b_inc, 0);

    check("pop_push_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
